// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU execution controller: run-state encodings,
// the default button debounce depth and a small state helper.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        BRK  = 2'b11
    } run_state_e;

    localparam int DBNC_CYCLES_DEF = 16;

    // The CPU is considered halted whenever it is parked waiting for the user.
    function automatic logic is_halted(run_state_e s);
        return (s == IDLE) || (s == BRK);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter that only
// accepts a level change after DBNC_CYCLES consecutive differing samples,
// and a one-cycle pulse on each accepted rising edge.
module btn_debounce #(
    parameter int DBNC_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = $clog2(DBNC_CYCLES) + 1;

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          pulse_q;
    logic          samp;

    assign samp    = sync_q[1];
    assign pulse_o = pulse_q;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b00;
        else         sync_q <= {sync_q[0], btn_i};
    end

    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample (a bounce back) restarts the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else if (samp == level_q) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else if (cnt_q == CW'(DBNC_CYCLES - 1)) begin
            level_q <= samp;
            cnt_q   <= '0;
            pulse_q <= samp;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
            pulse_q <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU execution controller: free-run, debounced single-step and optional
// halt-on-flag breakpoint, with an executed-cycle counter and a result
// snapshot for the LED display.
// Optional feature macro: CPU_RUN_CTRL_BRK_EN enables the ZF/OF breakpoint;
// without it Brk_En is ignored and the BRK state is never entered.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DBNC_CYCLES = DBNC_CYCLES_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Run_Sw,
    input  logic             Step_Btn,
    input  logic             Brk_En,
    input  logic             ZF,
    input  logic             OF,
    input  logic [31:0]      Result,
    output logic             Cpu_En,
    output logic [31:0]      Snap,
    output logic [1:0]       Snap_Flags,
    output logic [CNT_W-1:0] Cyc_Cnt,
    output logic             Halted,
    output logic [1:0]       State
);

    run_state_e        state_q, state_d;
    logic              halted_q;
    logic [1:0]        run_sync_q;
    logic              en_q;
    logic              brk_hit;
    logic              step_pulse;
    logic              run_sync;
    logic [31:0]       snap_q;
    logic [1:0]        flags_q;
    logic [CNT_W-1:0]  cyc_q;

    assign run_sync = run_sync_q[1];

    btn_debounce #(.DBNC_CYCLES(DBNC_CYCLES)) u_step_dbnc (
        .clk_i   (Clk),
        .rst_ni  (Rst),
        .btn_i   (Step_Btn),
        .pulse_o (step_pulse)
    );

    // Synchronise the run switch.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) run_sync_q <= 2'b00;
        else      run_sync_q <= {run_sync_q[0], Run_Sw};
    end

`ifdef CPU_RUN_CTRL_BRK_EN
    logic [1:0] brk_sync_q;

    // Synchronise the breakpoint enable switch.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) brk_sync_q <= 2'b00;
        else      brk_sync_q <= {brk_sync_q[0], Brk_En};
    end

    // Flags only mean something the cycle after an executed cycle.
    assign brk_hit = brk_sync_q[1] & en_q & (ZF | OF);
`else
    logic unused_brk_en;
    assign unused_brk_en = Brk_En;
    assign brk_hit       = 1'b0;
`endif

    // Combinational so the cycle after a flagging cycle is never executed.
    assign Cpu_En = ((state_q == RUN) || (state_q == STEP)) && !brk_hit;

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (run_sync)        state_d = RUN;
                  else if (step_pulse) state_d = STEP;
            RUN:  if (brk_hit)         state_d = BRK;
                  else if (!run_sync)  state_d = IDLE;
            STEP:                      state_d = IDLE;
            BRK:  if (!run_sync)       state_d = IDLE;
                  else if (step_pulse) state_d = STEP;
            default:                   state_d = IDLE;
        endcase
    end

    // State register with the registered Halted output.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= IDLE;
            halted_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            halted_q <= is_halted(state_d);
        end
    end

    // Remember whether the previous cycle executed (flags/result now valid).
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) en_q <= 1'b0;
        else      en_q <= Cpu_En;
    end

    // Capture the result of every executed cycle, including a flagging one.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            snap_q  <= '0;
            flags_q <= '0;
        end else if (en_q) begin
            snap_q  <= Result;
            flags_q <= {OF, ZF};
        end
    end

    // Saturating count of executed cycles.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)                  cyc_q <= '0;
        else if (Cpu_En && !(&cyc_q)) cyc_q <= cyc_q + 1'b1;
    end

    assign Snap       = snap_q;
    assign Snap_Flags = flags_q;
    assign Cyc_Cnt    = cyc_q;
    assign Halted     = halted_q;
    assign State      = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus a randomized phase, all
// compared cycle by cycle against a behavioural model of the controller.
// A second instance with a 4-bit counter exercises saturation.
module tb_cpu_run_ctrl;

`ifdef CPU_RUN_CTRL_BRK_EN
    localparam bit BRK_ON = 1'b1;
`else
    localparam bit BRK_ON = 1'b0;
`endif
    localparam int DBNC = 16;

    logic        Clk, Rst, Run_Sw, Step_Btn, Brk_En, ZF, OF;
    logic [31:0] Result;
    logic        Cpu_En, Halted, Cpu_En4, Halted4;
    logic [31:0] Snap, Snap4;
    logic [1:0]  Snap_Flags, Snap_Flags4, State, State4;
    logic [15:0] Cyc_Cnt;
    logic [3:0]  Cyc_Cnt4;

    cpu_run_ctrl #(.DBNC_CYCLES(DBNC), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .Run_Sw(Run_Sw), .Step_Btn(Step_Btn), .Brk_En(Brk_En),
        .ZF(ZF), .OF(OF), .Result(Result), .Cpu_En(Cpu_En), .Snap(Snap),
        .Snap_Flags(Snap_Flags), .Cyc_Cnt(Cyc_Cnt), .Halted(Halted), .State(State));

    cpu_run_ctrl #(.DBNC_CYCLES(DBNC), .CNT_W(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .Run_Sw(Run_Sw), .Step_Btn(Step_Btn), .Brk_En(Brk_En),
        .ZF(ZF), .OF(OF), .Result(Result), .Cpu_En(Cpu_En4), .Snap(Snap4),
        .Snap_Flags(Snap_Flags4), .Cyc_Cnt(Cyc_Cnt4), .Halted(Halted4), .State(State4));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;
    int en_seen = 0;

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 run, 2 single step, 3 break
    int        m_mode;
    bit        m_executed_last;
    bit        run_line[$], brk_line[$], btn_line[$];
    bit        btn_recent[$];
    bit        btn_accepted;
    bit        step_req;
    int        m_cycles, m_cycles4;
    bit [31:0] m_snap;
    bit [1:0]  m_flags;

    task automatic model_reset();
        m_mode = 0; m_executed_last = 0;
        run_line = '{0, 0}; brk_line = '{0, 0}; btn_line = '{0, 0};
        btn_recent.delete(); btn_accepted = 0; step_req = 0;
        m_cycles = 0; m_cycles4 = 0; m_snap = 0; m_flags = 0;
    endtask

    function automatic bit m_break();
        return BRK_ON && brk_line[0] && m_executed_last && (ZF === 1'b1 || OF === 1'b1);
    endfunction

    function automatic bit m_enable();
        return (m_mode == 1 || m_mode == 2) && !m_break();
    endfunction

    task automatic model_edge();
        bit run_on, hit, en, all_diff;
        int nxt;
        if (Rst !== 1'b1) begin model_reset(); return; end
        run_on = run_line[0];
        hit = m_break();
        en  = m_enable();
        nxt = m_mode;
        if (m_mode == 0)      nxt = run_on ? 1 : (step_req ? 2 : 0);
        else if (m_mode == 1) nxt = hit ? 3 : (run_on ? 1 : 0);
        else if (m_mode == 2) nxt = 0;
        else                  nxt = !run_on ? 0 : (step_req ? 2 : 3);
        if (en) begin
            m_cycles  = (m_cycles  < 65535) ? m_cycles + 1  : m_cycles;
            m_cycles4 = (m_cycles4 < 15)    ? m_cycles4 + 1 : m_cycles4;
        end
        if (m_executed_last) begin m_snap = Result; m_flags = {OF, ZF}; end
        m_executed_last = en;
        m_mode = nxt;
        // debounce: accept a new level once the last DBNC synced samples all differ
        step_req = 0;
        btn_recent.push_back(btn_line[0]);
        if (btn_recent.size() > DBNC) void'(btn_recent.pop_front());
        if (btn_recent.size() == DBNC) begin
            all_diff = 1;
            foreach (btn_recent[i]) if (btn_recent[i] == btn_accepted) all_diff = 0;
            if (all_diff) begin
                btn_accepted = ~btn_accepted;
                step_req = btn_accepted;
                btn_recent.delete();
            end
        end
        if (btn_line[0] == btn_accepted) btn_recent.delete();
        run_line.push_back(Run_Sw);   void'(run_line.pop_front());
        brk_line.push_back(Brk_En);   void'(brk_line.pop_front());
        btn_line.push_back(Step_Btn); void'(btn_line.pop_front());
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("state",   {30'd0, State},        32'(m_mode));
        chk("halted",  {31'd0, Halted},       32'(m_mode == 0 || m_mode == 3));
        chk("cpu_en",  {31'd0, Cpu_En},       32'(m_enable()));
        chk("cyc_cnt", {16'd0, Cyc_Cnt},      32'(m_cycles));
        chk("cyc4",    {28'd0, Cyc_Cnt4},     32'(m_cycles4));
        chk("snap",    Snap,                  m_snap);
        chk("flags",   {30'd0, Snap_Flags},   {30'd0, m_flags});
    endtask

    // compare mid-cycle, then advance one edge; returns 1 time unit after the edge
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            compare_all();
            en_seen += int'(Cpu_En === 1'b1);
            @(posedge Clk);
            model_edge();
            #1;
        end
    endtask

    int n;
    int hold;

    initial begin
        Rst = 1'b1; Run_Sw = 0; Step_Btn = 0; Brk_En = 0; ZF = 0; OF = 0; Result = 0;
        model_reset();
        #2 Rst = 1'b0;
        tick(2);
        chk("rst_state",  {30'd0, State}, 32'd0);
        chk("rst_halted", {31'd0, Halted}, 32'd1);
        Rst = 1'b1;

        // reset while running: enable must drop without waiting for a clock
        Run_Sw = 1;
        tick(6);
        chk("run_before_rst", {31'd0, Cpu_En}, 32'd1);
        #2 Rst = 1'b0; model_reset();
        #1 chk("async_rst_en", {31'd0, Cpu_En}, 32'd0);
        Run_Sw = 0;
        tick(3);
        Rst = 1'b1;
        tick(3);
        chk("post_rst_state", {30'd0, State}, 32'd0);
        chk("post_rst_cnt",   {16'd0, Cyc_Cnt}, 32'd0);
        chk("post_rst_snap",  Snap, 32'd0);

        // free run for ten cycles
        en_seen = 0;
        Run_Sw = 1; tick(10);
        Run_Sw = 0; tick(6);
        chk("run10_en_cycles", 32'(en_seen), 32'd10);
        chk("run10_cnt", {16'd0, Cyc_Cnt}, 32'd10);
        chk("run10_state", {30'd0, State}, 32'd0);

        // bouncing button never accepted, then a solid press and release
        en_seen = 0;
        for (int i = 0; i < 8; i++) begin Step_Btn = ~i[0]; tick(3); end
        Step_Btn = 1; tick(40);
        Step_Btn = 0; tick(40);
        chk("bounce_one_step", 32'(en_seen), 32'd1);
        chk("bounce_cnt", {16'd0, Cyc_Cnt}, 32'd11);

        // breakpoint on the fifth executed cycle
        Brk_En = 1; Run_Sw = 1; n = 0;
        for (int k = 0; k < 20 && n < 5; k++) begin
            if (m_enable()) n++;
            tick();
        end
        ZF = 1; Result = 32'hDEADBEEF;
        #1;
        if (BRK_ON) begin
            chk("brk_en_drop", {31'd0, Cpu_En}, 32'd0);
            tick();
            chk("brk_state", {30'd0, State}, 32'd3);
            chk("brk_snap", Snap, 32'hDEADBEEF);
            chk("brk_flags", {30'd0, Snap_Flags}, 32'd1);
            chk("brk_cnt", {16'd0, Cyc_Cnt}, 32'd16);
            // step past the break while the flag is still set
            Step_Btn = 1; hold = 0;
            while (!m_enable() && hold < 40) begin tick(); hold++; end
            chk("brk_step_timeout", 32'(hold < 40), 32'd1);
            chk("brk_step_state", {30'd0, State}, 32'd2);
            chk("brk_step_en", {31'd0, Cpu_En}, 32'd1);
            tick();
            chk("brk_step_idle", {30'd0, State}, 32'd0);
            chk("brk_step_off", {31'd0, Cpu_En}, 32'd0);
        end else begin
            chk("nobrk_en", {31'd0, Cpu_En}, 32'd1);
            tick();
            chk("nobrk_state", {30'd0, State}, 32'd1);
        end
        Run_Sw = 0; ZF = 0; Step_Btn = 0; Brk_En = 0;
        tick(30);

        // saturation of the narrow counter
        Run_Sw = 1; tick(20);
        Run_Sw = 0; tick(6);
        chk("sat4", {28'd0, Cyc_Cnt4}, 32'h0000000F);

        // randomized traffic
        hold = 0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 11) == 0) Run_Sw = ~Run_Sw;
            if ($urandom_range(0, 19) == 0) Brk_En = ~Brk_En;
            if (hold == 0) begin
                Step_Btn = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 30);
            end else hold--;
            ZF = ($urandom_range(0, 7) == 0);
            OF = ($urandom_range(0, 9) == 0);
            Result = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Execution controller between the board inputs and the CPU core. It gates the CPU with a clock enable and offers three modes: free-run, debounced single-step, and halt on a ZF/OF breakpoint. It counts executed cycles and snapshots the 32-bit result bus and flags so the LED byte selector shows a stable value while the core is halted.

## Interface
- DBNC_CYCLES, 16: consecutive stable samples required to accept a Step_Btn level change (≥2)
- CNT_W, 16: width of executed-cycle counter
- Clk  in  1  system clock, all logic rising-edge
- Rst  in  1  asynchronous, active-low reset
- Run_Sw  in  1  asynchronous level; 1 = free-run requested
- Step_Btn  in  1  raw, bouncing push button; one accepted press = one CPU cycle
- Brk_En  in  1  asynchronous level; 1 = halt when ZF or OF set
- ZF, OF  in  1 each  CPU flags, valid the cycle after an enabled CPU cycle
- Result  in  32  CPU result bus
- Cpu_En  out  1  CPU clock enable
- Snap  out  32  result captured after last executed cycle
- Snap_Flags  out  2  {OF, ZF} captured with Snap
- Cyc_Cnt  out  CNT_W  executed CPU cycles, saturating
- Halted  out  1  1 in IDLE or BRK
- State  out  2  IDLE=00, RUN=01, STEP=10, BRK=11

## Operation
- Run_Sw and Brk_En each pass through a 2-flop synchroniser. Step_Btn passes through a 2-flop synchroniser and then the debouncer. A rising edge of the debounced level produces a 1-cycle step_pulse.
- en_d is a register holding the previous cycle's Cpu_En.
- brk_hit = Brk_En_sync & en_d & (ZF | OF).
- Cpu_En = (State==RUN | State==STEP) & ~brk_hit. This is combinational, so the CPU never executes the cycle after a flagging cycle.
- IDLE:
  - run_sync=1 → RUN.
  - Otherwise step_pulse → STEP.
- RUN:
  - brk_hit → BRK. Takes priority over run_sync=0.
  - Else run_sync=0 → IDLE.
- STEP: one enabled cycle, then → IDLE unconditionally.
- BRK:
  - run_sync=0 → IDLE.
  - step_pulse → STEP. This steps past the break: en_d=0 on entry, so no immediate re-break.
  - run_sync=1 with no step: remain in BRK.
- Leaving IDLE to RUN with flags still set: the first RUN cycle executes. It re-breaks only if the new flags are set.
- Snapshot: when en_d=1 and brk_hit is not masking, Snap←Result and Snap_Flags←{OF,ZF}. The snapshot also captures on a brk_hit cycle, so the flagging result is shown.
- Cyc_Cnt increments on each Cpu_En=1 cycle and holds at all-ones.
- step_pulse arriving in RUN or STEP is discarded.

## Timing
- Reset values:
  - State=IDLE, Halted=1, Cpu_En=0, en_d=0.
  - Snap=0, Snap_Flags=0, Cyc_Cnt=0.
  - Synchronisers and debouncer cleared to 0.
- Reset asserted mid-run: Cpu_En drops to 0 asynchronously, with no partial step.
- Run_Sw edge → State change: 3 Clk edges (2 sync + state register).
- Step_Btn held stable 1 → step_pulse after 2+DBNC_CYCLES edges. STEP is entered on the next edge, giving exactly one Cpu_En=1 cycle.
- Any bounce shorter than DBNC_CYCLES restarts the stability count, and no pulse is produced.
- Holding the button produces a single step; a release must also be accepted before the next press.
- Breakpoint: the flagging cycle at T executes. Flags are seen at T+1 and Cpu_En=0 at T+1. State=BRK from T+2.
- Snap is valid 1 cycle after the executed cycle.

## Configuration
- CPU_RUN_CTRL_BRK_EN defined: breakpoint logic as above.
- CPU_RUN_CTRL_BRK_EN undefined:
  - brk_hit is tied to 0 and Brk_En is ignored.
  - BRK is unreachable; State never reads 11.
  - Snapshot still captures on every en_d=1 cycle.

## Structure
- Shared package cpu_ctrl_pkg holds the state encodings IDLE/RUN/STEP/BRK and the default DBNC_CYCLES.
- Sub-module btn_debounce contains the 2-flop sync, the stability counter sized clog2(DBNC_CYCLES)+1, and the rising-edge pulse. It is instantiated once, for Step_Btn.

## Test plan
- Reset with Rst=0 while in RUN → Cpu_En=0 immediately. After release: State=00, Halted=1, Cyc_Cnt=0, Snap=0.
- Run_Sw=1 for 10 cycles then 0, Brk_En=0 → Cpu_En high for exactly 10 cycles, Cyc_Cnt=10, final State=IDLE.
- Step_Btn bounces 0/1 every 3 cycles (DBNC_CYCLES=16), then holds 1 for 40 cycles → exactly one Cpu_En pulse and Cyc_Cnt +1.
- Run with Brk_En=1; drive ZF=1 after the 5th enabled cycle with Result=32'hDEADBEEF → Cpu_En=0 the next cycle, State=BRK, Snap=DEADBEEF, Snap_Flags=01, Cyc_Cnt=5.
- From BRK, one step press → one Cpu_En cycle with no re-break, then State=IDLE.
- Force Cyc_Cnt via CNT_W=4 and run for 20 cycles → Cyc_Cnt saturates at 4'hF.
